// File: rtl/queue_head_pointer_table.sv
// rtl/queue_head_pointer_table.sv - per-queue head pointer table, advanced on each AXI4-Lite read
// Reads return the pre-advance {page_ptr, head_ptr} two cycles later; page wrap follows a linked next page.
module queue_head_pointer_table #(
  parameter  int NUM_EGR_PORTS           = 2,
  parameter  int NUM_QUEUES_PER_EGR_PORT = 4,
  parameter  int BYTES_PER_PAGE          = 256,
  parameter  int NUM_PAGES               = 16,
  parameter  int DATA_BYTES              = 64,
  localparam int NUM_QUEUES = NUM_EGR_PORTS * NUM_QUEUES_PER_EGR_PORT,
  localparam int WPP        = (DATA_BYTES > 0) ? BYTES_PER_PAGE / DATA_BYTES : 1,
  localparam int QL         = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1,
  localparam int WL         = (WPP > 1) ? $clog2(WPP) : 1,
  localparam int PL         = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1,
  localparam int DW         = PL + WL
) (
  input  logic          i_clk,
  input  logic          i_aresetn,
  input  logic          i_arvalid,
  output logic          o_arready,
  input  logic [31:0]   i_araddr,
  input  logic [2:0]    i_arprot,
  output logic          o_rvalid,
  input  logic          i_rready,
  output logic [DW-1:0] o_rdata,
  output logic [1:0]    o_rresp,
  input  logic          i_awvalid,
  output logic          o_awready,
  input  logic [31:0]   i_awaddr,
  input  logic [2:0]    i_awprot,
  input  logic          i_wvalid,
  output logic          o_wready,
  input  logic [DW-1:0] i_wdata,
  output logic          o_bvalid,
  input  logic          i_bready,
  output logic [1:0]    o_bresp,
  input  logic          i_next_page_tvalid,
  output logic          o_next_page_tready,
  input  logic [PL-1:0] i_next_page_tdata,
  input  logic [QL-1:0] i_next_page_tuser,
  output logic [31:0]   o_underflow_count
);

  if (NUM_EGR_PORTS == 0 || NUM_QUEUES_PER_EGR_PORT == 0 || BYTES_PER_PAGE == 0 ||
      NUM_PAGES == 0 || DATA_BYTES == 0 || WPP == 0 || (WPP & (WPP - 1)) != 0) begin : g_bad_params
    $error("queue_head_pointer_table: zero parameter or non power-of-two words per page");
  end

  localparam logic [WL-1:0] HEAD_LAST   = WL'(WPP - 1);
  localparam logic [1:0]    RESP_OKAY   = 2'b00;
  localparam logic [1:0]    RESP_SLVERR = 2'b10;

  logic [PL-1:0]         r_page_ptr  [NUM_QUEUES];
  logic [WL-1:0]         r_head_ptr  [NUM_QUEUES];
  logic [PL-1:0]         r_next_page [NUM_QUEUES];
  logic [NUM_QUEUES-1:0] r_next_valid;
  logic [31:0]           r_underflow_count;
  logic                  r_s1_valid;
  logic                  r_s1_err;
  logic [DW-1:0]         r_s1_data;
  logic                  r_rvalid;
  logic [1:0]            r_rresp;
  logic [DW-1:0]         r_rdata;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;

  logic          w_rd_ok;
  logic [QL-1:0] w_rq;
  logic [PL-1:0] w_cur_page;
  logic [WL-1:0] w_cur_head;
  logic          w_at_last;
  logic          w_consume;
  logic          w_underflow;
  logic          w_wr_fire;
  logic          w_wr_ok;
  logic [QL-1:0] w_wq;
  logic          w_np_ok;
  logic [QL-1:0] w_nq;
  logic          w_unused;

  // The table is read and updated in the accept cycle, so back-to-back reads always see the advanced value.
  assign w_rd_ok     = i_arvalid && (i_araddr < 32'(NUM_QUEUES));
  assign w_rq        = i_araddr[QL-1:0];
  assign w_cur_page  = r_page_ptr[w_rq];
  assign w_cur_head  = r_head_ptr[w_rq];
  assign w_at_last   = (w_cur_head == HEAD_LAST);
  assign w_consume   = w_rd_ok && w_at_last && r_next_valid[w_rq];
  assign w_underflow = w_rd_ok && w_at_last && !r_next_valid[w_rq];

  assign w_wr_fire   = i_aresetn && i_awvalid && i_wvalid && !i_arvalid && !r_bvalid;
  assign w_wr_ok     = w_wr_fire && (i_awaddr < 32'(NUM_QUEUES));
  assign w_wq        = i_awaddr[QL-1:0];
  assign w_np_ok     = i_next_page_tvalid && (32'(i_next_page_tuser) < 32'(NUM_QUEUES));
  assign w_nq        = i_next_page_tuser;
  assign w_unused    = &{1'b0, i_arprot, i_awprot, i_rready};

  always_ff @(posedge i_clk) begin
    if (w_rd_ok) begin
      if (!w_at_last) begin
        r_head_ptr[w_rq] <= w_cur_head + WL'(1);
      end else begin
        r_head_ptr[w_rq] <= '0;
        if (r_next_valid[w_rq]) r_page_ptr[w_rq] <= r_next_page[w_rq];
      end
    end
    if (w_wr_ok) begin
      r_page_ptr[w_wq] <= i_wdata[DW-1:WL];
      r_head_ptr[w_wq] <= i_wdata[WL-1:0];
    end
    if (w_np_ok) r_next_page[w_nq] <= i_next_page_tdata;
  end

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_next_valid      <= '0;
      r_underflow_count <= '0;
      r_s1_valid        <= 1'b0;
      r_s1_err          <= 1'b0;
      r_s1_data         <= '0;
      r_rvalid          <= 1'b0;
      r_rresp           <= RESP_OKAY;
      r_rdata           <= '0;
      r_bvalid          <= 1'b0;
      r_bresp           <= RESP_OKAY;
    end else begin
      // A beat landing in the same cycle as a consuming read is kept: the set follows the clear.
      if (w_consume) r_next_valid[w_rq] <= 1'b0;
      if (w_np_ok)   r_next_valid[w_nq] <= 1'b1;
      if (w_underflow && (r_underflow_count != '1)) r_underflow_count <= r_underflow_count + 32'd1;
      r_s1_valid <= i_arvalid;
      r_s1_err   <= i_arvalid && !w_rd_ok;
      r_s1_data  <= w_rd_ok ? {w_cur_page, w_cur_head} : '0;
      r_rvalid   <= r_s1_valid;
      r_rresp    <= r_s1_err ? RESP_SLVERR : RESP_OKAY;
      r_rdata    <= r_s1_data;
      if (w_wr_fire) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (i_bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  assign o_arready          = 1'b1;
  assign o_rvalid           = r_rvalid;
  assign o_rdata            = r_rdata;
  assign o_rresp            = r_rresp;
  assign o_awready          = w_wr_fire;
  assign o_wready           = w_wr_fire;
  assign o_bvalid           = r_bvalid;
  assign o_bresp            = r_bresp;
  assign o_next_page_tready = 1'b1;
  assign o_underflow_count  = r_underflow_count;

endmodule

// File: tb/tb_queue_head_pointer_table.sv
// tb/tb_queue_head_pointer_table.sv - directed vector bench for queue_head_pointer_table
// Eight queues, four words per page, 16 pages: rdata/wdata = page*4 + head.
module tb_queue_head_pointer_table;

  localparam int DW = 6;
  localparam int OKAY = 0;
  localparam int SLVERR = 2;
  localparam int OP_W = 0, OP_R = 1, OP_N = 2, OP_U = 3;

  logic          clk = 1'b0;
  logic          aresetn;
  logic          arvalid, arready, rvalid, rready;
  logic [31:0]   araddr;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0]   awaddr;
  logic [DW-1:0] wdata;
  logic [1:0]    bresp;
  logic          np_tvalid, np_tready;
  logic [3:0]    np_tdata;
  logic [2:0]    np_tuser;
  logic [31:0]   underflow_count;

  int n_checks = 0;
  int n_fail   = 0;
  int burst_exp [8];

  typedef struct {
    int op;
    int q;
    int wdata;
    int exp;
    int resp;
  } vec_t;

  vec_t vecs [20];

  always #5 clk = ~clk;

  queue_head_pointer_table #(
    .NUM_EGR_PORTS(2), .NUM_QUEUES_PER_EGR_PORT(4), .BYTES_PER_PAGE(256),
    .NUM_PAGES(16), .DATA_BYTES(64)
  ) dut (
    .i_clk(clk), .i_aresetn(aresetn),
    .i_arvalid(arvalid), .o_arready(arready), .i_araddr(araddr), .i_arprot(3'b000),
    .o_rvalid(rvalid), .i_rready(rready), .o_rdata(rdata), .o_rresp(rresp),
    .i_awvalid(awvalid), .o_awready(awready), .i_awaddr(awaddr), .i_awprot(3'b000),
    .i_wvalid(wvalid), .o_wready(wready), .i_wdata(wdata),
    .o_bvalid(bvalid), .i_bready(bready), .o_bresp(bresp),
    .i_next_page_tvalid(np_tvalid), .o_next_page_tready(np_tready),
    .i_next_page_tdata(np_tdata), .i_next_page_tuser(np_tuser),
    .o_underflow_count(underflow_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_write(input int q, input int data, input int resp, input string name);
    int t = 0;
    @(negedge clk);
    awaddr = 32'(q); wdata = DW'(data); awvalid = 1'b1; wvalid = 1'b1;
    #1;
    while (!awready && t < 8) begin
      @(negedge clk); #1; t++;
    end
    chk({name, "_awready"}, {31'd0, awready}, 32'd1);
    chk({name, "_wready"}, {31'd0, wready}, 32'd1);
    @(negedge clk);
    chk({name, "_bvalid"}, {31'd0, bvalid}, 32'd1);
    chk({name, "_bresp"}, {30'd0, bresp}, 32'(resp));
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic do_read(input int q, input int exp, input int resp, input string name);
    @(negedge clk);
    araddr = 32'(q); arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    chk({name, "_early"}, {31'd0, rvalid}, 32'd0);
    @(negedge clk);
    chk({name, "_rvalid"}, {31'd0, rvalid}, 32'd1);
    chk({name, "_rdata"}, {26'd0, rdata}, 32'(exp));
    chk({name, "_rresp"}, {30'd0, rresp}, 32'(resp));
  endtask

  task automatic do_next(input int q, input int page);
    @(negedge clk);
    np_tuser = 3'(q); np_tdata = 4'(page); np_tvalid = 1'b1;
    @(negedge clk);
    np_tvalid = 1'b0;
  endtask

  // Consecutive-cycle reads of one queue; an optional beat rides along with the first read.
  task automatic burst(input int q, input int n, input int beat_page, input string name);
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        chk($sformatf("%s_rvalid%0d", name, i - 2), {31'd0, rvalid}, 32'd1);
        chk($sformatf("%s_rdata%0d", name, i - 2), {26'd0, rdata}, 32'(burst_exp[i - 2]));
      end
      arvalid = (i < n);
      araddr  = 32'(q);
      np_tvalid = (i == 0 && beat_page >= 0);
      np_tuser  = 3'(q);
      np_tdata  = 4'(beat_page);
    end
    @(negedge clk);
    chk({name, "_tail"}, {31'd0, rvalid}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{OP_W, 3, 20, 0, OKAY};
    vecs[1]  = '{OP_R, 3, 0, 20, OKAY};
    vecs[2]  = '{OP_R, 3, 0, 21, OKAY};
    vecs[3]  = '{OP_W, 2, 19, 0, OKAY};
    vecs[4]  = '{OP_R, 2, 0, 19, OKAY};
    vecs[5]  = '{OP_U, 0, 0, 1, OKAY};
    vecs[6]  = '{OP_R, 2, 0, 16, OKAY};
    vecs[7]  = '{OP_W, 1, 31, 0, OKAY};
    vecs[8]  = '{OP_N, 1, 9, 0, OKAY};
    vecs[9]  = '{OP_R, 1, 0, 31, OKAY};
    vecs[10] = '{OP_R, 1, 0, 36, OKAY};
    vecs[11] = '{OP_W, 8, 0, 0, SLVERR};
    vecs[12] = '{OP_R, 8, 0, 0, SLVERR};
    vecs[13] = '{OP_W, 0, 62, 0, OKAY};
    vecs[14] = '{OP_R, 0, 0, 62, OKAY};
    vecs[15] = '{OP_R, 0, 0, 63, OKAY};
    vecs[16] = '{OP_U, 0, 0, 2, OKAY};
    vecs[17] = '{OP_R, 0, 0, 60, OKAY};
    vecs[18] = '{OP_R, 3, 0, 22, OKAY};
    vecs[19] = '{OP_R, 1, 0, 37, OKAY};

    aresetn = 1'b0; arvalid = 1'b0; araddr = '0; rready = 1'b1;
    awvalid = 1'b1; wvalid = 1'b1; awaddr = '0; wdata = '0; bready = 1'b1;
    np_tvalid = 1'b0; np_tdata = '0; np_tuser = '0;
    repeat (3) @(negedge clk);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("rst_awready", {31'd0, awready}, 32'd0);
    chk("rst_wready", {31'd0, wready}, 32'd0);
    chk("rst_underflow", underflow_count, 32'd0);
    chk("arready_const", {31'd0, arready}, 32'd1);
    chk("tready_const", {31'd0, np_tready}, 32'd1);
    aresetn = 1'b1; awvalid = 1'b0; wvalid = 1'b0;

    for (int i = 0; i < 20; i++) begin
      case (vecs[i].op)
        OP_W: do_write(vecs[i].q, vecs[i].wdata, vecs[i].resp, $sformatf("vec%0d", i));
        OP_R: do_read(vecs[i].q, vecs[i].exp, vecs[i].resp, $sformatf("vec%0d", i));
        OP_N: do_next(vecs[i].q, vecs[i].wdata);
        default: chk($sformatf("vec%0d_underflow", i), underflow_count, 32'(vecs[i].exp));
      endcase
    end

    do_write(3, 20, OKAY, "b2b_wr");
    burst_exp[0] = 20; burst_exp[1] = 21; burst_exp[2] = 22;
    burst(3, 3, -1, "b2b");

    do_write(1, 31, OKAY, "merge_wr");
    do_next(1, 9);
    burst_exp[0] = 31; burst_exp[1] = 36; burst_exp[2] = 37;
    burst_exp[3] = 38; burst_exp[4] = 39; burst_exp[5] = 44;
    burst(1, 6, 11, "merge");
    chk("merge_underflow", underflow_count, 32'd2);

    @(negedge clk);
    arvalid = 1'b1; araddr = 32'd8;
    awvalid = 1'b1; wvalid = 1'b1; awaddr = 32'd4; wdata = DW'(13);
    #1;
    chk("hold_awready", {31'd0, awready}, 32'd0);
    @(negedge clk);
    arvalid = 1'b0;
    #1;
    chk("hold_release", {31'd0, awready}, 32'd1);
    @(negedge clk);
    chk("oor_rvalid", {31'd0, rvalid}, 32'd1);
    chk("oor_rresp", {30'd0, rresp}, 32'(SLVERR));
    chk("oor_rdata", {26'd0, rdata}, 32'd0);
    chk("hold_bvalid", {31'd0, bvalid}, 32'd1);
    chk("hold_bresp", {30'd0, bresp}, 32'(OKAY));
    awvalid = 1'b0; wvalid = 1'b0;
    do_read(4, 13, OKAY, "hold_rd");

    do_next(5, 12);
    @(negedge clk);
    arvalid = 1'b1; araddr = 32'd3;
    @(negedge clk);
    @(posedge clk);
    #1;
    aresetn = 1'b0; arvalid = 1'b0; awvalid = 1'b1; wvalid = 1'b1; awaddr = 32'd0;
    #1;
    chk("mid_rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("mid_rst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("mid_rst_awready", {31'd0, awready}, 32'd0);
    chk("mid_rst_underflow", underflow_count, 32'd0);
    repeat (2) @(negedge clk);
    aresetn = 1'b1; awvalid = 1'b0; wvalid = 1'b0;
    arvalid = 1'b1; araddr = 32'd6;
    @(negedge clk);
    arvalid = 1'b0;
    chk("post_rst_flushed", {31'd0, rvalid}, 32'd0);
    @(negedge clk);
    chk("post_rst_first_rvalid", {31'd0, rvalid}, 32'd1);
    chk("post_rst_first_rresp", {30'd0, rresp}, 32'(OKAY));
    @(negedge clk);
    chk("post_rst_single", {31'd0, rvalid}, 32'd0);

    do_write(5, 11, OKAY, "nv_wr");
    do_read(5, 11, OKAY, "nv_rd0");
    do_read(5, 8, OKAY, "nv_rd1");
    chk("nv_underflow", underflow_count, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
